systolic_sequencer: RTL and testbench

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

---
 rtl/systolic_sequencer.sv | 158 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Job sequencer for an 8x8 systolic array.
// A job runs through four phases: it loads 8 weight columns, streams N_VEC
// activation vectors, drains the results, then signals completion.
// If the array stops returning results for DRAIN_MAX cycles while draining,
// the job ends with a sticky timeout flag.
module systolic_sequencer #(
   parameter int N_VEC     = 8,
   parameter int DRAIN_MAX = 63
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        float_in,
   input  logic [63:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [7:0]  arr_load,
   output logic [63:0] arr_value,
   output logic        arr_valid,
   output logic        arr_float,
   input  logic        arr_out_valid,
   input  logic [63:0] arr_out_value,
   input  logic        arr_overflow,
   output logic [63:0] res_data,
   output logic        res_valid,
   output logic        busy,
   output logic        done,
   output logic        ovf_flag,
   output logic        timeout
);

   // The idle counter must reach DRAIN_MAX without wrapping; it is never narrower than 6 bits.
   localparam int IW = (DRAIN_MAX < 64) ? 6 : $clog2(DRAIN_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [2:0]      r_col_cnt;
   logic [7:0]      r_vec_cnt;
   logic [7:0]      r_res_cnt;
   logic [IW-1:0]   r_idle_cnt;
   logic            r_float;
   logic [63:0]     r_res_data;
   logic            r_res_valid;
   logic            r_ovf;
   logic            r_timeout;

   logic            w_start_ok;
   logic            w_in_job;
   logic            w_capture;
   logic            w_drain_done;
   logic            w_idle_hit;

   assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_in_job     = (r_state == S_STREAM) || (r_state == S_DRAIN);
   assign w_capture    = w_in_job && arr_out_valid;
   // The drain ends on the N_VEC-th result. It also ends when every result already arrived during streaming.
   assign w_drain_done = (r_state == S_DRAIN) &&
                         ((w_capture && r_res_cnt == 8'(N_VEC - 1)) || r_res_cnt >= 8'(N_VEC));
   assign w_idle_hit   = (r_state == S_DRAIN) && !arr_out_valid && (r_idle_cnt == IW'(DRAIN_MAX - 1));

   // State register.
   // NOTE: sequential state uses non-blocking (<=) assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   // NOTE: each combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_LOAD;
         S_LOAD:   if (src_valid && r_col_cnt == 3'd7) w_next = S_STREAM;
         S_STREAM: if (src_valid && r_vec_cnt == 8'(N_VEC - 1)) w_next = S_DRAIN;
         S_DRAIN:  if (w_drain_done || w_idle_hit) w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Array-side strobes and handshakes, combinational from state and src_data.
   always_comb begin
      src_ready = 1'b0;
      arr_load  = 8'd0;
      arr_valid = 1'b0;
      arr_value = 64'd0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_LOAD: begin
            src_ready = 1'b1;
            busy      = 1'b1;
            if (src_valid) begin
               arr_load  = 8'b1 << r_col_cnt;
               arr_value = src_data;
            end
         end
         S_STREAM: begin
            src_ready = 1'b1;
            busy      = 1'b1;
            if (src_valid) begin
               arr_valid = 1'b1;
               arr_value = src_data;
            end
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Job counters, result capture and sticky flags.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_col_cnt   <= '0;
         r_vec_cnt   <= '0;
         r_res_cnt   <= '0;
         r_idle_cnt  <= '0;
         r_float     <= 1'b0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         if (w_start_ok) begin
            r_col_cnt  <= '0;
            r_vec_cnt  <= '0;
            r_res_cnt  <= '0;
            r_idle_cnt <= '0;
            r_ovf      <= 1'b0;
            r_timeout  <= 1'b0;
            r_float    <= float_in;
         end else begin
            if (r_state == S_LOAD && src_valid)   r_col_cnt <= r_col_cnt + 3'd1;
            if (r_state == S_STREAM && src_valid) r_vec_cnt <= r_vec_cnt + 8'd1;
            if (w_capture) begin
               r_res_data  <= arr_out_value;
               r_res_valid <= 1'b1;
               if (r_res_cnt != 8'hFF) r_res_cnt <= r_res_cnt + 8'd1;
            end
            if (w_in_job) r_ovf <= r_ovf | arr_overflow;
            // The idle count only runs while draining and restarts on every result.
            if (r_state != S_DRAIN || arr_out_valid) r_idle_cnt <= '0;
            else                                      r_idle_cnt <= r_idle_cnt + IW'(1);
            if (w_idle_hit && !w_drain_done) r_timeout <= 1'b1;
         end
      end
   end

   assign arr_float = r_float;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign ovf_flag  = r_ovf;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer; the bench plays both the upstream source and the array.
module tb_systolic_sequencer;

   localparam int N_VEC = 8;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        start = 1'b0;
   logic        float_in = 1'b0;
   logic [63:0] src_data = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [7:0]  arr_load;
   logic [63:0] arr_value;
   logic        arr_valid;
   logic        arr_float;
   logic        arr_out_valid = 1'b0;
   logic [63:0] arr_out_value = '0;
   logic        arr_overflow = 1'b0;
   logic [63:0] res_data;
   logic        res_valid;
   logic        busy;
   logic        done;
   logic        ovf_flag;
   logic        timeout;

   int   n_checks = 0;
   int   n_errors = 0;
   logic capt_en  = 1'b0;  // high while the DUT is in STREAM or DRAIN and captures results

   systolic_sequencer #(.N_VEC(N_VEC), .DRAIN_MAX(63)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .float_in(float_in),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .arr_load(arr_load), .arr_value(arr_value), .arr_valid(arr_valid),
      .arr_float(arr_float), .arr_out_valid(arr_out_valid),
      .arr_out_value(arr_out_value), .arr_overflow(arr_overflow),
      .res_data(res_data), .res_valid(res_valid), .busy(busy), .done(done),
      .ovf_flag(ovf_flag), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock. A result offered while capturing must appear on res_* one cycle later.
   task automatic tick();
      logic        erv;
      logic [63:0] erd;
      erv = capt_en && arr_out_valid;
      erd = arr_out_value;
      @(posedge clk); #1;
      check("res_valid", 64'(res_valid), 64'(erv));
      if (erv) check("res_data", res_data, erd);
   endtask

   task automatic start_job(input logic f);
      start = 1'b1; float_in = f; capt_en = 1'b0;
      tick();
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("src_ready_load", 64'(src_ready), 64'd1);
      check("arr_float", 64'(arr_float), 64'(f));
      check("ovf_cleared", 64'(ovf_flag), 64'd0);
      check("timeout_cleared", 64'(timeout), 64'd0);
   endtask

   // Load weights 0x01..0x08. Optionally insert a bubble, an ignored result and an ignored start.
   task automatic load_weights(input bit bubble, input bit extras);
      for (int i = 0; i < 8; i++) begin
         if (bubble && i == 4) begin
            src_valid = 1'b0; src_data = 64'hDEAD; #1;
            check("load_bubble_strobe", 64'(arr_load), 64'd0);
            check("load_bubble_value", arr_value, 64'd0);
            tick();
         end
         src_valid = 1'b1; src_data = 64'(i + 1);
         arr_out_valid = extras && i == 0; arr_out_value = 64'hBAD;
         start = extras && i == 2;
         #1;
         check("arr_load", 64'(arr_load), 64'd1 << i);
         check("arr_value_load", arr_value, 64'(i + 1));
         check("arr_valid_in_load", 64'(arr_valid), 64'd0);
         tick();
         arr_out_valid = 1'b0; start = 1'b0;
      end
      src_valid = 1'b0;
      capt_en = 1'b1;
   endtask

   // Stream N_VEC vectors. Results are offered on the first n_res cycles and overflow on cycle ovf_at.
   task automatic stream(input bit toggle, input int n_res, input int ovf_at);
      int          sent = 0, cyc = 0, pulses = 0;
      logic        v;
      logic [63:0] ev;
      while (sent < N_VEC && cyc < 100) begin
         v = toggle ? (cyc % 2 == 0) : 1'b1;
         ev = v ? 64'h5000 + 64'(cyc) : 64'd0;
         src_valid = v; src_data = 64'h5000 + 64'(cyc);
         arr_out_valid = (cyc < n_res); arr_out_value = 64'hC000 + 64'(cyc);
         arr_overflow = (cyc == ovf_at);
         #1;
         check("arr_valid_stream", 64'(arr_valid), 64'(v));
         check("arr_value_stream", arr_value, ev);
         check("arr_load_stream", 64'(arr_load), 64'd0);
         if (arr_valid) pulses++;
         if (v) sent++;
         tick();
         cyc++;
      end
      arr_out_valid = 1'b0; arr_overflow = 1'b0;
      check("arr_valid_pulses", 64'(pulses), 64'(N_VEC));
      // Now in DRAIN: the source is refused and the array sees nothing.
      src_valid = 1'b1; #1;
      check("drain_src_ready", 64'(src_ready), 64'd0);
      check("drain_arr_valid", 64'(arr_valid), 64'd0);
      check("drain_arr_value", arr_value, 64'd0);
      check("drain_busy", 64'(busy), 64'd1);
      src_valid = 1'b0;
   endtask

   // Return n results in DRAIN with one-cycle gaps. Optionally assert start alongside the last result.
   task automatic drain_results(input int n, input bit start_on_last);
      for (int k = 0; k < n; k++) begin
         arr_out_valid = 1'b1; arr_out_value = 64'hD000 + 64'(k);
         start = start_on_last && k == n - 1;
         #1;
         check("done_before_last", 64'(done), 64'd0);
         tick();
         arr_out_valid = 1'b0; start = 1'b0;
         if (k < n - 1) tick();
      end
      capt_en = 1'b0;
      check("done_after_results", 64'(done), 64'd1);
      check("busy_after_results", 64'(busy), 64'd0);
      check("no_timeout", 64'(timeout), 64'd0);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_src_ready", 64'(src_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data", res_data, 64'd0);
      check("rst_flags", {62'd0, ovf_flag, timeout}, 64'd0);
      check("rst_arr_float", 64'(arr_float), 64'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;

      // Job A: float mode, toggling stream, overflow once, 8 results, start alongside the last result
      start_job(1'b1);
      load_weights(1'b0, 1'b1);
      stream(1'b1, 2, 3);
      check("ovf_set_in_stream", 64'(ovf_flag), 64'd1);
      drain_results(6, 1'b1);
      check("ovf_held_done", 64'(ovf_flag), 64'd1);
      arr_out_valid = 1'b1; arr_out_value = 64'hEEEE;
      tick();                                    // result in DONE is ignored
      arr_out_valid = 1'b0;
      check("done_stays", 64'(done), 64'd1);
      check("ovf_still_held", 64'(ovf_flag), 64'd1);

      // Job B: integer mode, bubble in load, only 7 results -> drain timeout
      start_job(1'b0);
      load_weights(1'b1, 1'b0);
      stream(1'b0, 7, -1);
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      capt_en = 1'b0;
      check("drain_timeout_cycles", 64'(n), 64'd63);
      check("timeout_set", 64'(timeout), 64'd1);
      check("timeout_busy", 64'(busy), 64'd0);

      // Job C: reset asserted mid-drain
      start_job(1'b1);
      load_weights(1'b0, 1'b0);
      stream(1'b0, 0, 2);
      arr_out_valid = 1'b1; arr_out_value = 64'h1234;
      tick();
      arr_out_valid = 1'b0;
      #2 n_rst = 1'b0;
      capt_en = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_res_valid", 64'(res_valid), 64'd0);
      check("arst_res_data", res_data, 64'd0);
      check("arst_ovf", 64'(ovf_flag), 64'd0);
      check("arst_timeout", 64'(timeout), 64'd0);
      check("arst_arr_float", 64'(arr_float), 64'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      src_valid = 1'b1; #1;
      check("post_rst_src_ready", 64'(src_ready), 64'd0);
      check("post_rst_arr_load", 64'(arr_load), 64'd0);
      check("post_rst_done", 64'(done), 64'd0);
      src_valid = 1'b0;
      tick();

      // Job D: a normal job after reset
      start_job(1'b0);
      load_weights(1'b0, 1'b0);
      stream(1'b0, 0, -1);
      drain_results(8, 1'b0);
      check("jobd_ovf", 64'(ovf_flag), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
